simd_execute_unit: RTL and testbench
====================================

// Module: simd_execute_unit
// PURPOSE
//   Execute stage of the SIMD processor: PE_COUNT parallel processing elements (PEs) apply one
//   shared op to lane pairs a[i], b[i] and register the results on elem_out. A dot-product path
//   sums all lane products and accumulates the sum into a scalar. Completed scalars shift through
//   the dot_out vector, so PE_COUNT dot products can be collected for writeback.
// PARAMETERS
//   PE_COUNT    4  number of lanes / PEs (>=2)
//   DATA_WIDTH  8  lane width in bits, two's-complement signed
// PORTS
//   clk          in   1                     single clock, rising edge
//   rstn         in   1                     asynchronous, active-high reset (asserted while rstn==1)
//   a            in   PE_COUNT*DATA_WIDTH   signed operand vector, packed [PE_COUNT-1:0][DATA_WIDTH-1:0]
//   b            in   PE_COUNT*DATA_WIDTH   signed operand vector, same packing
//   pe_op        in   OP_SEL_WIDTH (2)      00 PASS_B, 01 ADD, 10 SUB (a-b), 11 MUL
//   dot_prod_en  in   1                     enables the dot-product accumulate/shift path
//   shift        in   1                     with dot_prod_en: start a new dot product (shift dot_out)
//   elem_out     out  PE_COUNT*DATA_WIDTH   registered element-wise result
//   dot_out      out  PE_COUNT*DATA_WIDTH   dot-product result shift register; lane 0 = current
// BEHAVIOUR
//   - Reset (async, rstn==1): elem_out=0, dot_out=0. Reset mid-accumulation discards all partial
//     sums. Outputs stay 0 while reset is held.
//   - Element path: every clock, elem_out[i] <= op(a[i], b[i]).
//       Latency 1 cycle. No handshake. Updates regardless of dot_prod_en.
//   - Arithmetic: signed; ADD, SUB and MUL keep the low DATA_WIDTH bits (wrap, no saturation).
//       MUL keeps the low DATA_WIDTH bits of the full 2*DATA_WIDTH product.
//   - Dot path: psum = sum over i of (a[i]*b[i]). Each product and the sum are truncated to
//     DATA_WIDTH (wrap). The product is formed independently of pe_op.
//   - dot_prod_en=1, shift=1: dot_out[k] <= dot_out[k-1] for k=1..PE_COUNT-1, dot_out[0] <= psum.
//     The oldest value in dot_out[PE_COUNT-1] is dropped.
//   - dot_prod_en=1, shift=0: dot_out[0] <= dot_out[0] + psum (wrap); other lanes hold.
//   - dot_prod_en=0: dot_out holds; shift is ignored.
//   - dot_out latency: 1 cycle from operands to dot_out[0].
// STRUCTURE
//   - Shared package / params.svh: OP_SEL_WIDTH=2 and enum pe_op_t {PASS_B, ADD, SUB, MUL}.
//   - Sub-module pe: one lane, combinational; inputs a, b, op; outputs result and product.
//     Instantiated PE_COUNT times in a generate loop.
//   - Top level contains the elem_out register, the adder tree, and the dot_out
//     accumulator/shift register.
// TESTING (PE_COUNT=4, DATA_WIDTH=8, vectors listed lane3..lane0, one stimulus per clock)
//   1. Reset: rstn=1 with random inputs -> elem_out=0, dot_out=0; release rstn=0, outputs update.
//   2. a={01,02,03,04}, b={10,20,30,40}:
//        op00 -> {10,20,30,40}; op01 -> {11,22,33,44}; op10 -> {F1,E2,D3,C4}; op11 -> {10,40,90,00}.
//   3. Dot product, dot_prod_en=1:
//        cycle 1: a=b=all 01, shift=1 -> dot_out[0]=04.
//        cycle 2: a=b=all 02, shift=0 -> dot_out[0]=14 (20 decimal).
//        Repeat the pair 4 times -> dot_out={14,14,14,14}.
//   4. Hold: after test 3 set dot_prod_en=0, toggle shift and operands -> dot_out unchanged;
//      elem_out still tracks op.
//   5. Wrap: a=b=all 7F, op11 -> elem_out=all 01; dot_prod_en=1, shift=1 -> dot_out[0]=04.
//   6. Reset mid-accumulation: assert rstn during shift=0 accumulation -> dot_out=0 immediately,
//      without waiting for a clock edge.

Source files
------------

// File: rtl/simd_execute_unit_pkg.sv
// Shared types for the SIMD execute stage.
// Holds the PE opcode encoding used by the top and every lane.
package simd_execute_unit_pkg;

  localparam int OP_SEL_WIDTH = 2;

  typedef enum logic [OP_SEL_WIDTH-1:0] {
    PASS_B = 2'b00,
    ADD    = 2'b01,
    SUB    = 2'b10,
    MUL    = 2'b11
  } pe_op_t;

endpackage

// File: rtl/simd_execute_unit_pe.sv
// One SIMD lane: combinational element op plus the lane product.
// All arithmetic wraps to the lane width.
module simd_execute_unit_pe
  import simd_execute_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  pe_op_t                op,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] full;

  assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign full  = a_ext * b_ext;

  // The dot path always gets the product, whatever op is selected.
  assign product = full[DATA_WIDTH-1:0];

  always_comb begin
    result = b;
    unique case (op)
      PASS_B: result = b;
      ADD:    result = a + b;
      SUB:    result = a - b;
      MUL:    result = full[DATA_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/simd_execute_unit.sv
// SIMD execute stage: registered element-wise results and a
// dot-product accumulator feeding a shift register of scalars.
module simd_execute_unit
  import simd_execute_unit_pkg::*;
#(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] a,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] b,
  input  logic [OP_SEL_WIDTH-1:0]        pe_op,
  input  logic                           dot_prod_en,
  input  logic                           shift,
  output logic [PE_COUNT*DATA_WIDTH-1:0] elem_out,
  output logic [PE_COUNT*DATA_WIDTH-1:0] dot_out
);

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t   a_v;
  vec_t   b_v;
  vec_t   res;
  vec_t   prod;
  vec_t   elem_q;
  vec_t   dot_q;
  pe_op_t op;

  logic [DATA_WIDTH-1:0] psum;

  assign a_v = vec_t'(a);
  assign b_v = vec_t'(b);
  assign op  = pe_op_t'(pe_op);

  for (genvar i = 0; i < PE_COUNT; i++) begin : g_pe
    simd_execute_unit_pe #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_pe (
      .a      (a_v[i]),
      .b      (b_v[i]),
      .op     (op),
      .result (res[i]),
      .product(prod[i])
    );
  end

  // Sum of lane products, wrapping at lane width.
  always_comb begin
    psum = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      psum = psum + prod[i];
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      elem_q <= '0;
    end else begin
      elem_q <= res;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      dot_q <= '0;
    end else if (dot_prod_en) begin
      if (shift) begin
        dot_q <= {dot_q[PE_COUNT-2:0], psum};
      end else begin
        dot_q[0] <= dot_q[0] + psum;
      end
    end
  end

  assign elem_out = elem_q;
  assign dot_out  = dot_q;

endmodule

// File: tb/tb_simd_execute_unit.sv
// Bench for simd_execute_unit: lane-level model checked every
// cycle, plus directed vectors with literal expectations.
module tb_simd_execute_unit;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk;
  logic          rstn;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [1:0]    pe_op;
  logic          dot_prod_en;
  logic          shift;
  logic [31:0]   elem_out;
  logic [31:0]   dot_out;

  int n_cmp;
  int n_bad;

  int m_elem [N];
  int m_dot  [N];

  simd_execute_unit #(
    .PE_COUNT  (N),
    .DATA_WIDTH(W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .a          (a),
    .b          (b),
    .pe_op      (pe_op),
    .dot_prod_en(dot_prod_en),
    .shift      (shift),
    .elem_out   (elem_out),
    .dot_out    (dot_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int lane(input logic [31:0] v, input int i);
    logic [7:0] x;
    x = v[8*i +: 8];
    return int'($signed(x));
  endfunction

  function automatic logic [31:0] pack(input int v [N]);
    logic [31:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(v[i]);
    return r;
  endfunction

  // Reference model: plain integer arithmetic, wrapped to 8 bits.
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < N; i++) begin
        m_elem[i] = 0;
        m_dot[i]  = 0;
      end
    end else begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
        int x;
        int y;
        x = lane(a, i);
        y = lane(b, i);
        s += x * y;
        case (pe_op)
          2'd0: m_elem[i] = y & 255;
          2'd1: m_elem[i] = (x + y) & 255;
          2'd2: m_elem[i] = (x - y) & 255;
          default: m_elem[i] = (x * y) & 255;
        endcase
      end
      if (dot_prod_en) begin
        if (shift) begin
          for (int k = N - 1; k > 0; k--) m_dot[k] = m_dot[k-1];
          m_dot[0] = s & 255;
        end else begin
          m_dot[0] = (m_dot[0] + s) & 255;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_elem", elem_out, pack(m_elem));
    chk("model_dot", dot_out, pack(m_dot));
  end

  task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] op, input logic en,
                       input logic sh);
    a           = av;
    b           = bv;
    pe_op       = op;
    dot_prod_en = en;
    shift       = sh;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] held;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    drive($urandom, $urandom, 2'($urandom), 1'b1, 1'b1);
    #1 rstn = 1'b1;

    // 1. reset with random inputs
    tick();
    drive($urandom, $urandom, 2'($urandom), 1'b1, 1'b0);
    tick();
    chk("rst_elem", elem_out, 32'h0);
    chk("rst_dot", dot_out, 32'h0);
    rstn = 1'b0;

    // 2. element ops
    drive(32'h01020304, 32'h10203040, 2'd0, 1'b0, 1'b0);
    tick();
    chk("op_pass", elem_out, 32'h10203040);
    chk("rel_dot", dot_out, 32'h0);
    drive(32'h01020304, 32'h10203040, 2'd1, 1'b0, 1'b0);
    tick();
    chk("op_add", elem_out, 32'h11223344);
    drive(32'h01020304, 32'h10203040, 2'd2, 1'b0, 1'b0);
    tick();
    chk("op_sub", elem_out, 32'hF1E2D3C4);
    drive(32'h01020304, 32'h10203040, 2'd3, 1'b0, 1'b0);
    tick();
    chk("op_mul", elem_out, 32'h10409000);

    // 3. dot products
    for (int r = 0; r < 4; r++) begin
      drive(32'h01010101, 32'h01010101, 2'd1, 1'b1, 1'b1);
      tick();
      chk("dot_shift", {24'h0, dot_out[7:0]}, 32'h04);
      drive(32'h02020202, 32'h02020202, 2'd1, 1'b1, 1'b0);
      tick();
      chk("dot_acc", {24'h0, dot_out[7:0]}, 32'h14);
    end
    chk("dot_vec", dot_out, 32'h14141414);

    // 4. hold while disabled
    held = dot_out;
    for (int r = 0; r < 4; r++) begin
      drive(32'h01020304, 32'h10203040, 2'd1, 1'b0, 1'(r));
      tick();
      chk("hold_dot", dot_out, held);
      chk("hold_elem", elem_out, 32'h11223344);
    end

    // 5. wrap
    drive(32'h7F7F7F7F, 32'h7F7F7F7F, 2'd3, 1'b1, 1'b1);
    tick();
    chk("wrap_elem", elem_out, 32'h01010101);
    chk("wrap_dot", dot_out, 32'h14141404);

    // 6. async reset mid-accumulation
    drive(32'h01010101, 32'h01010101, 2'd0, 1'b1, 1'b1);
    tick();
    drive(32'h01010101, 32'h01010101, 2'd0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_dot0", {24'h0, dot_out[7:0]}, 32'h08);
    #1 rstn = 1'b1;
    #1;
    chk("async_dot", dot_out, 32'h0);
    chk("async_elem", elem_out, 32'h0);
    tick();
    chk("held_rst_dot", dot_out, 32'h0);
    rstn = 1'b0;

    // mixed traffic against the model
    for (int r = 0; r < 40; r++) begin
      drive($urandom, $urandom, 2'($urandom), 1'($urandom),
            1'($urandom));
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
